// File: rtl/vga_rect_writer_if.sv
// Command and video-memory write-port bundle for the rectangle fill engine.
// master: the command issuer that also observes the write port. slave: the engine.
interface vga_rect_writer_if #(
  parameter int unsigned COLOR_DEPTH = 6,
  parameter int unsigned nX          = 8,
  parameter int unsigned nY          = 7,
  parameter int unsigned Mn          = 15
);
  logic                   start;
  logic                   ready;
  logic [nX-1:0]          x0;
  logic [nY-1:0]          y0;
  logic [nX-1:0]          w;
  logic [nY-1:0]          h;
  logic [COLOR_DEPTH-1:0] color;
  logic                   abort;
  logic                   wr_en;
  logic [Mn-1:0]          wr_addr;
  logic [COLOR_DEPTH-1:0] wr_data;
  logic                   done;

  modport master (
    output start, x0, y0, w, h, color, abort,
    input  ready, wr_en, wr_addr, wr_data, done
  );

  modport slave (
    input  start, x0, y0, w, h, color, abort,
    output ready, wr_en, wr_addr, wr_data, done
  );
endinterface

// File: rtl/vga_rect_writer.sv
// Filled-rectangle drawing engine: one pixel write per cycle, row-major, addr = y*COLS + x.
// Optional RECT_CLIP_EN: off-screen pixels keep their cycle but are not written.
module vga_rect_writer #(
  parameter int unsigned COLOR_DEPTH = 6,
  parameter int unsigned nX          = 8,
  parameter int unsigned nY          = 7,
  parameter int unsigned Mn          = 15,
  parameter int unsigned COLS        = 160,
  parameter int unsigned ROWS        = 120
) (
  input  logic            vga_clock,
  input  logic            resetn,
  vga_rect_writer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The frame buffer has to fit in the write address space.
  if (COLS * ROWS > (32'd1 << Mn)) begin : g_bad_geometry
    $error("vga_rect_writer: COLS*ROWS exceeds the Mn-bit address space");
  end

  state_e                 state_q, state_d;
  logic [nX-1:0]          x0_q, x0_d, w_q, w_d, cx_q, cx_d;
  logic [nY-1:0]          y0_q, y0_d, h_q, h_d, cy_q, cy_d;
  logic [COLOR_DEPTH-1:0] color_q, color_d;
  logic                   wr_en_q, wr_en_d;
  logic [Mn-1:0]          wr_addr_q, wr_addr_d;
  logic [COLOR_DEPTH-1:0] wr_data_q, wr_data_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;

  logic                   emit;
  logic                   last_px;
  logic                   on_screen;
  logic [nX:0]            px;
  logic [nY:0]            py;

  // Outputs are registered from the next state, so each state shows its own outputs.
  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    ready_d   = 1'b0;
    emit      = 1'b0;
    last_px   = (cx_q == nX'(w_q - nX'(1))) && (cy_q == nY'(h_q - nY'(1)));

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x0_d    = bus.x0;
          y0_d    = bus.y0;
          w_d     = bus.w;
          h_d     = bus.h;
          color_d = bus.color;
          cx_d    = '0;
          cy_d    = '0;
          if ((bus.w == '0) || (bus.h == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_DRAW;
            emit    = 1'b1;
          end
        end
      end
      S_DRAW: begin
        if (bus.abort || last_px) begin
          state_d = S_DONE;
        end else begin
          emit = 1'b1;
          if (cx_q == nX'(w_q - nX'(1))) begin
            cx_d = '0;
            cy_d = nY'(cy_q + nY'(1));
          end else begin
            cx_d = nX'(cx_q + nX'(1));
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    px = (nX+1)'(x0_d) + (nX+1)'(cx_d);
    py = (nY+1)'(y0_d) + (nY+1)'(cy_d);

`ifdef RECT_CLIP_EN
    on_screen = (32'(px) < COLS) && (32'(py) < ROWS);
`else
    on_screen = 1'b1;
`endif

    // Address and data only move on a real write; otherwise they hold.
    if (emit && on_screen) begin
      wr_en_d   = 1'b1;
      wr_addr_d = Mn'(32'(py) * COLS + 32'(px));
      wr_data_d = color_d;
    end

    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge vga_clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      x0_q      <= '0;
      y0_q      <= '0;
      w_q       <= '0;
      h_q       <= '0;
      color_q   <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      x0_q      <= x0_d;
      y0_q      <= y0_d;
      w_q       <= w_d;
      h_q       <= h_d;
      color_q   <= color_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.ready   = ready_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.done    = done_q;

endmodule

// File: doc/vga_rect_writer.md
Name: vga_rect_writer

Overview:
- Drawing engine on the write port of the video memory; the VGA scan-out reads that memory on its other port.
- Accepts one filled-rectangle command per handshake: origin, size and colour.
- Emits one pixel write per cycle, row-major, with the memory address computed as y*COLS + x.
- Used by game logic, e.g. to paint and clear the Simon pads.

Parameters:
- COLOR_DEPTH, 6, bits per pixel word (R,G,B each COLOR_DEPTH/3 bits, R in MSBs)
- nX, 8, x coordinate / width bit width
- nY, 7, y coordinate / height bit width
- Mn, 15, memory address width
- COLS, 160, pixels per row in memory
- ROWS, 120, rows in memory

Ports:
- vga_clock  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  command valid; accepted only when ready=1
- ready  out  1  high in IDLE only
- x0  in  nX  rectangle left column
- y0  in  nY  rectangle top row
- w  in  nX  width in pixels
- h  in  nY  height in pixels
- color  in  COLOR_DEPTH  fill colour
- abort  in  1  terminate current command
- wr_en  out  1  video memory write enable
- wr_addr  out  Mn  video memory write address
- wr_data  out  COLOR_DEPTH  video memory write data
- done  out  1  one-cycle pulse at command completion

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; ready=1; wr_en=0; wr_addr=0; wr_data=0; done=0.
  - All internal counters cleared.
  - Reset mid-command abandons it silently: no done pulse, no further writes.
- States: IDLE, DRAW, DONE.
- IDLE:
  - ready=1.
  - On start=1, latch x0, y0, w, h and color.
  - If w==0 or h==0, go to DONE; otherwise go to DRAW with cx=0, cy=0.
  - start is ignored in all other states.
- DRAW:
  - Every cycle: X=x0+cx (nX+1 bits), Y=y0+cy (nY+1 bits).
  - Registered outputs: wr_en=1, wr_addr=(Y*COLS+X) truncated to Mn bits, wr_data=latched color.
  - cx increments each cycle. When cx==w-1, cx goes to 0 and cy increments.
  - After the write of cx==w-1, cy==h-1, go to DONE.
- Timing:
  - First write visible on the outputs the cycle after the start-accept edge.
  - Exactly w*h consecutive wr_en cycles, with no bubbles.
- DONE:
  - done=1 for exactly one cycle; wr_en=0; go to IDLE. ready returns the following cycle.
- Abort:
  - abort=1 in DRAW: the write registered on that edge is suppressed (wr_en=0) and the next state is DONE.
  - abort in IDLE or DONE has no effect.
- Output hold: wr_addr and wr_data hold their last values when wr_en=0.
- Arithmetic:
  - The multiply is a plain product synthesised to constants/shifts.
  - No pipelining beyond the single output register stage.
- Colour: not modified; the scan-out side performs any bit replication.
- start and abort together in IDLE: start wins.

Optional Feature:
- Macro: RECT_CLIP_EN.
- Defined:
  - A pixel with X>=COLS or Y>=ROWS still consumes its cycle, but wr_en=0 for it.
  - Off-screen pixels never touch memory.
  - Cycle count and done timing are unchanged.
- Undefined:
  - Every pixel is written.
  - The address wraps modulo 2^Mn.
  - The caller guarantees on-screen rectangles.

Test Plan:
- Reset mid-DRAW (x0=0,y0=0,w=10,h=10, reset at 5th write) -> wr_en=0 and ready=1 immediately; no done pulse; next command runs normally.
- start with x0=2,y0=3,w=3,h=2,color=6'h2A:
  - exactly 6 writes in consecutive cycles, addresses 482,483,484,642,643,644, data 6'h2A;
  - done pulses one cycle after the last write; ready=1 the cycle after.
- w=0,h=5 -> no wr_en; done pulses 1 cycle after accept.
- start held high throughout a w=4,h=1 command -> second command accepted only after ready returns, and its writes follow.
- abort on the 3rd write cycle of w=4,h=4 -> exactly 2 writes (addresses 0,1 for origin 0,0); done pulses on the next cycle.
- RECT_CLIP_EN defined:
  - x0=158,y0=119,w=4,h=2 -> 8 DRAW cycles, writes only at addresses 19198 and 19199, then done.
  - Without the macro, all 8 writes are asserted with the address wrapped to 15 bits.
